// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants and types for the instruction-fetch stage.
//   ZeroWord / NopInst  : 32-bit zero word and the nop encoding loaded on bubbles
//   Stop / NoStop       : decode stall encodings
//   Branch / NotBranch  : decode branch flag encodings
//   RESET_PC_DEFAULT    : default first fetch address after reset
//   fetch_entry_t       : {pc, inst} pair held by the fetch buffer
package if_stage_pkg;

    localparam logic [31:0] ZeroWord         = 32'h0000_0000;
    localparam logic [31:0] NopInst          = 32'h0000_0000;
    localparam logic        Stop             = 1'b1;
    localparam logic        NoStop           = 1'b0;
    localparam logic        Branch           = 1'b1;
    localparam logic        NotBranch        = 1'b0;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: single-entry {pc, inst} holding buffer. Catches an instruction
// that completes while decode is stalled so it is not lost.
//   clk, rst   : clock, asynchronous active-low reset
//   wr_en      : load wr_data, mark valid
//   wr_data    : entry to store
//   rd_en      : entry consumed, mark empty
//   rd_data    : stored entry
//   valid      : 1 = rd_data holds an unconsumed instruction
module if_fetch_buf
    import if_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  fetch_entry_t wr_data,
    input  logic         rd_en,
    output fetch_entry_t rd_data,
    output logic         valid
);

    // Write and read never coincide (write needs a stall, read needs advance);
    // write is given priority anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= 1'b0;
            rd_data <= '0;
        end else if (wr_en) begin
            valid   <= 1'b1;
            rd_data <= wr_data;
        end else if (rd_en) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with IF/ID pipeline register.
// Runs a single-outstanding req/rvalid handshake to instruction memory,
// holds IF/ID on decode stall and applies decode branch redirects after the
// delay slot has been fetched.
//   clk, rst          : clock, asynchronous active-low reset
//   stall_i           : decode stall, 1 = hold IF/ID
//   branch_flag_i     : decode branch request
//   branch_target_i   : decode branch target
//   imem_req_o        : fetch request
//   imem_addr_o       : fetch address (= pc)
//   imem_rvalid_i     : completion of current request
//   imem_rdata_i      : fetched instruction
//   id_pc_o/id_inst_o : IF/ID register contents
//   id_valid_o        : 1 = id_inst_o is a real instruction
// Optional macro IF_PERF_CNT_EN adds fetch_cnt_o (completions) and
// bubble_cnt_o (cycles where IF/ID loads a bubble).
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);

    logic [31:0]  pc;
    logic         pend_valid;
    logic [31:0]  pend_target;
    logic         fb_valid;
    fetch_entry_t fb_data;
    fetch_entry_t fb_wr_data;
    logic         completion;
    logic         advance;
    logic         redirect_accept;

    // rst gates the request so it drops the instant reset asserts; the
    // internal completion term needs no gating since every flop is held in
    // reset while rst=0.
    assign imem_req_o      = rst & ~fb_valid;
    assign imem_addr_o     = pc;
    assign completion      = ~fb_valid & imem_rvalid_i;
    assign advance         = (stall_i == NoStop);
    assign redirect_accept = (branch_flag_i == Branch) & advance & id_valid_o;
    assign fb_wr_data      = '{pc: pc, inst: imem_rdata_i};

    if_fetch_buf u_fetch_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (completion & ~advance),
        .wr_data (fb_wr_data),
        .rd_en   (advance & fb_valid),
        .rd_data (fb_data),
        .valid   (fb_valid)
    );

    // The branch sits in IF/ID, so pc always points at (or past) its delay
    // slot. If the delay slot is already in fb or completes this cycle, jump
    // straight to the target; otherwise park the target until it completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= ZeroWord;
        end else begin
            if (completion) begin
                if (pend_valid)
                    pc <= pend_target;
                else if (redirect_accept)
                    pc <= branch_target_i;
                else
                    pc <= seq_pc(pc);
            end else if (redirect_accept && fb_valid) begin
                pc <= branch_target_i;
            end

            if (completion) begin
                pend_valid <= 1'b0;
            end else if (redirect_accept && !fb_valid) begin
                pend_valid  <= 1'b1;
                pend_target <= branch_target_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc_o    <= ZeroWord;
            id_inst_o  <= NopInst;
            id_valid_o <= 1'b0;
        end else if (advance) begin
            if (fb_valid) begin
                id_pc_o    <= fb_data.pc;
                id_inst_o  <= fb_data.inst;
                id_valid_o <= 1'b1;
            end else if (completion) begin
                id_pc_o    <= pc;
                id_inst_o  <= imem_rdata_i;
                id_valid_o <= 1'b1;
            end else begin
                id_pc_o    <= ZeroWord;
                id_inst_o  <= NopInst;
                id_valid_o <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_o  <= 32'd0;
            bubble_cnt_o <= 32'd0;
        end else begin
            if (completion)
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (advance && !fb_valid && !completion)
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end
    end
`endif

endmodule
